// File: rtl/toeplitz_pkg.sv
// Shared types and helpers for the streaming Toeplitz matrix builder.
package toeplitz_pkg;

  localparam int DEF_DW = 16;
  localparam int DEF_AW = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    STREAM,
    DONE
  } state_t;

  // Coefficient index feeding element (i,j): i-j+n-1 in general mode,
  // |i-j| in symmetric mode.
  function automatic int unsigned coef_idx(input int unsigned i,
                                           input int unsigned j,
                                           input int unsigned n,
                                           input logic        sym);
    if (sym) begin
      return (i >= j) ? (i - j) : (j - i);
    end
    return i + n - 1 - j;
  endfunction

endpackage

// File: rtl/toeplitz_coef_buf.sv
// Local coefficient store: K x DW register file, one synchronous write port
// from the load path, one combinational read port for the stream path.
// Contents are deliberately not reset.
module toeplitz_coef_buf #(
  parameter int DW = 16,
  parameter int K  = 15,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [K];

  // Capture load-path data into the addressed slot.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < K)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Combinational read for the stream counters.
  always_comb begin
    rdata = '0;
    if (int'(raddr) < K) begin
      rdata = mem_q[raddr];
    end
  end

endmodule

// File: rtl/toeplitz_stream.sv
// Fetches 2N-1 (or N in symmetric mode) coefficients from a synchronous-read
// memory, then streams the N x N Toeplitz matrix row-major over valid/ready.
// Optional symmetric mode (extra `sym` input) is enabled by defining
// TOEPLITZ_SYMMETRIC_EN.
module toeplitz_stream
  import toeplitz_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int N  = 8,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
`ifdef TOEPLITZ_SYMMETRIC_EN
  input  logic          sym,
`endif
  output logic          rd,
  output logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [CW-1:0] m_row,
  output logic [CW-1:0] m_col,
  output logic          m_last,
  output logic          busy,
  output logic          done
);

  localparam int KMAX = 2 * N - 1;
  localparam int KW   = $clog2(KMAX);

  state_t        state_q, state_d;
  logic [AW-1:0] base_q;
  logic          sym_q;
  logic [KW-1:0] k_q;
  logic          rd_q;
  logic [AW-1:0] addr_q;
  logic          wr_en_q;
  logic [KW-1:0] wr_idx_q;
  logic [CW-1:0] row_q, col_q;
  logic [DW-1:0] m_data_q;
  logic          m_valid_q;
  logic          m_last_q;
  logic          done_q;

  logic          sym_in;
  logic [KW-1:0] k_last;
  logic          accept;
  logic          at_end;
  logic [CW-1:0] ni, nj;
  logic [KW-1:0] raddr;
  logic [DW-1:0] rdata;

`ifdef TOEPLITZ_SYMMETRIC_EN
  assign sym_in = sym;
`else
  assign sym_in = 1'b0;
`endif

  assign k_last = sym_q ? KW'(N - 1) : KW'(KMAX - 1);
  assign accept = m_valid_q && m_ready;
  assign at_end = (row_q == CW'(N - 1)) && (col_q == CW'(N - 1));

  // Coordinates of the element to present next; DRAIN primes (0,0).
  always_comb begin
    ni = row_q;
    nj = col_q;
    if (state_q == DRAIN) begin
      ni = '0;
      nj = '0;
    end else if (col_q == CW'(N - 1)) begin
      ni = row_q + CW'(1);
      nj = '0;
    end else begin
      nj = col_q + CW'(1);
    end
  end

  assign raddr = KW'(coef_idx(32'(ni), 32'(nj), 32'(N), sym_q));

  toeplitz_coef_buf #(
    .DW (DW),
    .K  (KMAX),
    .IW (KW)
  ) u_coef_buf (
    .clk   (clk),
    .we    (wr_en_q),
    .waddr (wr_idx_q),
    .wdata (data),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (k_q == k_last) state_d = DRAIN;
      DRAIN:   state_d = STREAM;
      STREAM:  if (accept && at_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus registered read port and stream outputs.
  // Memory data trails rd by one cycle, so writes follow a delayed copy of
  // rd with their own index; the final word lands on the DRAIN edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      base_q    <= '0;
      sym_q     <= 1'b0;
      k_q       <= '0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      row_q     <= '0;
      col_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      wr_en_q <= rd_q;
      if (wr_en_q) begin
        wr_idx_q <= wr_idx_q + KW'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            sym_q    <= sym_in;
            k_q      <= '0;
            rd_q     <= 1'b1;
            addr_q   <= base_addr;
            wr_idx_q <= '0;
          end
        end
        LOAD: begin
          if (k_q == k_last) begin
            rd_q <= 1'b0;
          end else begin
            k_q    <= k_q + KW'(1);
            addr_q <= base_q + AW'(k_q) + AW'(1);
          end
        end
        DRAIN: begin
          m_valid_q <= 1'b1;
          row_q     <= '0;
          col_q     <= '0;
          m_data_q  <= rdata;
          m_last_q  <= 1'b0;
        end
        STREAM: begin
          if (accept) begin
            if (at_end) begin
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              row_q     <= '0;
              col_q     <= '0;
              done_q    <= 1'b1;
            end else begin
              row_q    <= ni;
              col_q    <= nj;
              m_data_q <= rdata;
              m_last_q <= (ni == CW'(N - 1)) && (nj == CW'(N - 1));
            end
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign rd      = rd_q;
  assign addr    = addr_q;
  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_row   = row_q;
  assign m_col   = col_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule
